hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller_pkg.sv | 43 ++++
 rtl/hazard_controller_if.sv | 45 ++++
 rtl/hazard_controller_sat_counter.sv | 26 ++
 rtl/hazard_controller.sv | 130 +++++++++++++
 tb/tb_hazard_controller.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared pipeline types for hazard detection: bypass selectors, controller
// states, the execute/memory shadow slot record and the operand-match helpers.
package PipelineTypes;

    localparam int COUNT_WIDTH = 32;

    typedef logic [4:0] RegNum;

    typedef enum logic [1:0] {
        BYPASS_NONE = 2'd0,
        BYPASS_EXEC = 2'd1,
        BYPASS_MEM  = 2'd2
    } BypassCtrl;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } HazardState;

    // isLoad only matters in the execute slot; the memory slot keeps it clear.
    typedef struct packed {
        logic  valid;
        RegNum rd;
        logic  we;
        logic  isLoad;
    } PipeSlot;

    localparam PipeSlot SLOT_EMPTY = '0;

    // x0 is hard-wired, so it is never a forwarding source.
    function automatic logic slotMatches(PipeSlot slot, RegNum rs, logic rsUsed);
        return slot.valid && slot.we && (slot.rd == rs) && (rs != 5'd0) && rsUsed;
    endfunction

    function automatic BypassCtrl selectBypass(PipeSlot exSlot, PipeSlot memSlot,
                                               RegNum rs, logic rsUsed);
        if (slotMatches(exSlot, rs, rsUsed)) return BYPASS_EXEC;
        if (slotMatches(memSlot, rs, rsUsed)) return BYPASS_MEM;
        return BYPASS_NONE;
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Decode-side view of the hazard controller: instruction fields in, bypass and
// pipeline control out, plus the event counters and their preload hook.
interface hazard_controller_if;
    import PipelineTypes::*;

    logic                   decValid;
    RegNum                  decRs1;
    RegNum                  decRs2;
    logic                   decRs1Used;
    logic                   decRs2Used;
    RegNum                  decRd;
    logic                   decRdWe;
    logic                   decIsLoad;
    logic                   branchPredictMiss;

    // Debug preload of the event counters, sampled on the state-update edge.
    logic                   stallCountLoad;
    logic                   flushCountLoad;
    logic [COUNT_WIDTH-1:0] countLoadValue;

    BypassCtrl              op1BypassCtrl;
    BypassCtrl              op2BypassCtrl;
    logic                   stallFetch;
    logic                   stallDecode;
    logic                   flushDecode;
    logic [COUNT_WIDTH-1:0] stallCount;
    logic [COUNT_WIDTH-1:0] flushCount;

    modport master (
        output decValid, decRs1, decRs2, decRs1Used, decRs2Used,
               decRd, decRdWe, decIsLoad, branchPredictMiss,
               stallCountLoad, flushCountLoad, countLoadValue,
        input  op1BypassCtrl, op2BypassCtrl, stallFetch, stallDecode,
               flushDecode, stallCount, flushCount
    );

    modport slave (
        input  decValid, decRs1, decRs2, decRs1Used, decRs2Used,
               decRd, decRdWe, decIsLoad, branchPredictMiss,
               stallCountLoad, flushCountLoad, countLoadValue,
        output op1BypassCtrl, op2BypassCtrl, stallFetch, stallDecode,
               flushDecode, stallCount, flushCount
    );

endinterface

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter with a synchronous preload; updates on the falling
// clock edge to line up with the pipeline registers.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Decode-stage hazard controller: operand forwarding select, load-use stall,
// mispredict flush sequencing and stall/flush event counting.
module hazard_controller
    import PipelineTypes::*;
(
    input  logic               clk,
    input  logic               rst,
    hazard_controller_if.slave hz
);

    HazardState state;
    HazardState nextState;
    PipeSlot    exSlot;
    PipeSlot    memSlot;
    PipeSlot    decSlot;
    PipeSlot    agedSlot;

    logic loadUse;
    logic issue;
    logic stallReq;
    logic flushReq;
    logic stallEntry;
    logic flushEntry;
    logic bypassEnable;

    assign decSlot  = '{valid: 1'b1, rd: hz.decRd, we: hz.decRdWe, isLoad: hz.decIsLoad};
    assign agedSlot = '{valid: exSlot.valid, rd: exSlot.rd, we: exSlot.we, isLoad: 1'b0};

    // A load in execute has no data until memory, so a dependent decode must wait.
    assign loadUse = hz.decValid && exSlot.isLoad &&
                     (slotMatches(exSlot, hz.decRs1, hz.decRs1Used) ||
                      slotMatches(exSlot, hz.decRs2, hz.decRs2Used));

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        nextState = state;
        stallReq  = 1'b0;
        flushReq  = 1'b0;
        issue     = 1'b0;
        unique case (state)
            RUN: begin
                if (hz.branchPredictMiss) begin
                    flushReq  = 1'b1;
                    nextState = FLUSH;
                end else if (loadUse) begin
                    stallReq  = 1'b1;
                    nextState = LOAD_STALL;
                end else begin
                    issue = hz.decValid;
                end
            end
            LOAD_STALL: begin
                if (hz.branchPredictMiss) begin
                    flushReq  = 1'b1;
                    nextState = FLUSH;
                end else begin
                    issue     = hz.decValid;
                    nextState = RUN;
                end
            end
            FLUSH: begin
                flushReq  = 1'b1;
                nextState = RUN;
            end
            default: nextState = RUN;
        endcase
    end

    assign stallEntry = (state == RUN) && (nextState == LOAD_STALL);
    assign flushEntry = (state != FLUSH) && (nextState == FLUSH);

    // Outputs are qualified by rst so they read idle while reset is held,
    // independent of whatever the decode stage is presenting.
    assign hz.stallFetch  = rst && stallReq;
    assign hz.stallDecode = rst && stallReq;
    assign hz.flushDecode = rst && flushReq;

    assign bypassEnable = rst && hz.decValid && (state != FLUSH);

    always_comb begin
        hz.op1BypassCtrl = BYPASS_NONE;
        hz.op2BypassCtrl = BYPASS_NONE;
        if (bypassEnable) begin
            hz.op1BypassCtrl = selectBypass(exSlot, memSlot, hz.decRs1, hz.decRs1Used);
            hz.op2BypassCtrl = selectBypass(exSlot, memSlot, hz.decRs2, hz.decRs2Used);
        end
    end

    // NOTE: the slots are a handful of flops, not a memory, so they take the
    // async reset directly; a reset mid-sequence leaves no stale forwarding source.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            exSlot  <= SLOT_EMPTY;
            memSlot <= SLOT_EMPTY;
        end else begin
            state <= nextState;
            if (state == FLUSH) begin
                exSlot  <= SLOT_EMPTY;
                memSlot <= SLOT_EMPTY;
            end else begin
                exSlot  <= issue ? decSlot : SLOT_EMPTY;
                memSlot <= agedSlot;
            end
        end
    end

    sat_counter #(
        .WIDTH(COUNT_WIDTH)
    ) stallCounter (
        .clk       (clk),
        .rst       (rst),
        .inc       (stallEntry),
        .load      (hz.stallCountLoad),
        .loadValue (hz.countLoadValue),
        .count     (hz.stallCount)
    );

    sat_counter #(
        .WIDTH(COUNT_WIDTH)
    ) flushCounter (
        .clk       (clk),
        .rst       (rst),
        .inc       (flushEntry),
        .load      (hz.flushCountLoad),
        .loadValue (hz.countLoadValue),
        .count     (hz.flushCount)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: each scenario drives decode traffic and
// queues the expected control outputs; a monitor compares them mid-cycle.
module tb_hazard_controller;
    import PipelineTypes::*;

    typedef struct {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       isLoad;
        logic       miss;
    } Instr;

    typedef struct {
        string     name;
        BypassCtrl op1;
        BypassCtrl op2;
        logic      stall;
        logic      flush;
    } Expect;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    Expect scoreboard[$];
    Expect cur;

    hazard_controller_if hz();

    hazard_controller dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    // State updates on the falling edge; inputs change on the rising edge.
    always #5 clk = ~clk;

    function automatic Instr alu(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
        Instr i;
        i = '{valid: 1'b1, rs1: rs1, rs2: rs2, u1: 1'b1, u2: 1'b1,
              rd: rd, we: 1'b1, isLoad: 1'b0, miss: 1'b0};
        return i;
    endfunction

    function automatic Instr ld(logic [4:0] rd, logic [4:0] rs1);
        Instr i;
        i = '{valid: 1'b1, rs1: rs1, rs2: 5'd0, u1: 1'b1, u2: 1'b0,
              rd: rd, we: 1'b1, isLoad: 1'b1, miss: 1'b0};
        return i;
    endfunction

    function automatic Instr idle();
        Instr i;
        i = '{valid: 1'b0, rs1: 5'd0, rs2: 5'd0, u1: 1'b0, u2: 1'b0,
              rd: 5'd0, we: 1'b0, isLoad: 1'b0, miss: 1'b0};
        return i;
    endfunction

    function automatic Expect want(string name, BypassCtrl op1, BypassCtrl op2,
                                   logic stall, logic flush);
        Expect e;
        e = '{name: name, op1: op1, op2: op2, stall: stall, flush: flush};
        return e;
    endfunction

    task automatic drive(input Instr i);
        hz.decValid          = i.valid;
        hz.decRs1            = i.rs1;
        hz.decRs2            = i.rs2;
        hz.decRs1Used        = i.u1;
        hz.decRs2Used        = i.u2;
        hz.decRd             = i.rd;
        hz.decRdWe           = i.we;
        hz.decIsLoad         = i.isLoad;
        hz.branchPredictMiss = i.miss;
    endtask

    // One pipeline cycle: present the instruction, queue what the controller
    // should answer, and return before the falling edge commits it.
    task automatic step(input Instr i, input Expect e);
        @(posedge clk);
        drive(i);
        scoreboard.push_back(e);
        #3;
    endtask

    task automatic idleSteps();
        step(idle(), want("idle", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b0));
        step(idle(), want("idle", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b0));
    endtask

    task automatic resetDut();
        rst = 1'b0;
        drive(idle());
        @(posedge clk);
        @(posedge clk);
        rst = 1'b1;
    endtask

    always @(posedge clk) begin
        #2;
        if (scoreboard.size() > 0) begin
            cur = scoreboard.pop_front();
            checks++;
            if (hz.op1BypassCtrl !== cur.op1) begin
                failures++;
                $display("FAIL %s op1BypassCtrl: got %0d want %0d", cur.name, hz.op1BypassCtrl, cur.op1);
            end
            checks++;
            if (hz.op2BypassCtrl !== cur.op2) begin
                failures++;
                $display("FAIL %s op2BypassCtrl: got %0d want %0d", cur.name, hz.op2BypassCtrl, cur.op2);
            end
            checks++;
            if (hz.stallFetch !== cur.stall) begin
                failures++;
                $display("FAIL %s stallFetch: got %b want %b", cur.name, hz.stallFetch, cur.stall);
            end
            checks++;
            if (hz.stallDecode !== cur.stall) begin
                failures++;
                $display("FAIL %s stallDecode: got %b want %b", cur.name, hz.stallDecode, cur.stall);
            end
            checks++;
            if (hz.flushDecode !== cur.flush) begin
                failures++;
                $display("FAIL %s flushDecode: got %b want %b", cur.name, hz.flushDecode, cur.flush);
            end
        end
    end

    task automatic checkCounts(input string name, input logic [31:0] stallWant,
                               input logic [31:0] flushWant);
        checks++;
        if (hz.stallCount !== stallWant) begin
            failures++;
            $display("FAIL %s stallCount: got %h want %h", name, hz.stallCount, stallWant);
        end
        checks++;
        if (hz.flushCount !== flushWant) begin
            failures++;
            $display("FAIL %s flushCount: got %h want %h", name, hz.flushCount, flushWant);
        end
    endtask

    task automatic test_reset();
        Instr i;
        rst = 1'b0;
        i = alu(5'd7, 5'd3, 5'd3);
        i.miss = 1'b1;
        drive(i);
        #12;
        checks++;
        if ({hz.stallFetch, hz.stallDecode, hz.flushDecode} !== 3'b000) begin
            failures++;
            $display("FAIL reset controls: got %b want 000",
                     {hz.stallFetch, hz.stallDecode, hz.flushDecode});
        end
        checks++;
        if (hz.op1BypassCtrl !== BYPASS_NONE || hz.op2BypassCtrl !== BYPASS_NONE) begin
            failures++;
            $display("FAIL reset bypass: got %0d/%0d want 0/0", hz.op1BypassCtrl, hz.op2BypassCtrl);
        end
        checkCounts("reset", 32'd0, 32'd0);
        drive(idle());
        @(posedge clk);
        rst = 1'b1;
        idleSteps();
    endtask

    task automatic test_exec_bypass();
        idleSteps();
        step(alu(5'd5, 5'd1, 5'd2), want("exec_add", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b0));
        step(alu(5'd6, 5'd5, 5'd1), want("exec_sub", BYPASS_EXEC, BYPASS_NONE, 1'b0, 1'b0));
    endtask

    task automatic test_mem_bypass();
        idleSteps();
        step(alu(5'd5, 5'd1, 5'd2), want("mem_add", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b0));
        step(alu(5'd8, 5'd9, 5'd10), want("mem_unrel", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b0));
        step(alu(5'd7, 5'd1, 5'd5), want("mem_or", BYPASS_NONE, BYPASS_MEM, 1'b0, 1'b0));
        idleSteps();
        step(alu(5'd5, 5'd1, 5'd2), want("prio_a", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b0));
        step(alu(5'd5, 5'd3, 5'd4), want("prio_b", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b0));
        step(alu(5'd6, 5'd5, 5'd5), want("prio_use", BYPASS_EXEC, BYPASS_EXEC, 1'b0, 1'b0));
    endtask

    task automatic test_load_use();
        idleSteps();
        step(ld(5'd3, 5'd1), want("lu_lw", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b0));
        step(alu(5'd4, 5'd3, 5'd3), want("lu_stall", BYPASS_EXEC, BYPASS_EXEC, 1'b1, 1'b0));
        step(alu(5'd4, 5'd3, 5'd3), want("lu_release", BYPASS_MEM, BYPASS_MEM, 1'b0, 1'b0));
        checkCounts("lu_counts", 32'd1, 32'd0);
        step(idle(), want("lu_after", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b0));
    endtask

    task automatic test_x0_and_unused();
        Instr i;
        idleSteps();
        step(alu(5'd0, 5'd1, 5'd2), want("x0_write", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b0));
        step(alu(5'd9, 5'd0, 5'd0), want("x0_read", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b0));
        step(ld(5'd0, 5'd1), want("x0_lw", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b0));
        step(alu(5'd9, 5'd0, 5'd0), want("x0_lw_use", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b0));
        step(alu(5'd5, 5'd1, 5'd2), want("unused_src", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b0));
        i = alu(5'd6, 5'd5, 5'd5);
        i.u2 = 1'b0;
        step(i, want("unused_op2", BYPASS_EXEC, BYPASS_NONE, 1'b0, 1'b0));
        i.valid = 1'b0;
        step(i, want("invalid_dec", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b0));
    endtask

    task automatic test_miss_and_load();
        Instr i;
        resetDut();
        idleSteps();
        step(ld(5'd3, 5'd1), want("ml_lw", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b0));
        i = alu(5'd4, 5'd3, 5'd3);
        i.miss = 1'b1;
        step(i, want("ml_miss", BYPASS_EXEC, BYPASS_EXEC, 1'b0, 1'b1));
        step(alu(5'd4, 5'd3, 5'd3), want("ml_flush", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b1));
        checkCounts("ml_counts", 32'd0, 32'd1);
        step(alu(5'd5, 5'd4, 5'd3), want("ml_cleared", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b0));
    endtask

    task automatic test_stall_abort();
        Instr i;
        idleSteps();
        step(ld(5'd3, 5'd1), want("ab_lw", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b0));
        step(alu(5'd4, 5'd3, 5'd3), want("ab_stall", BYPASS_EXEC, BYPASS_EXEC, 1'b1, 1'b0));
        i = alu(5'd4, 5'd3, 5'd3);
        i.miss = 1'b1;
        step(i, want("ab_miss", BYPASS_MEM, BYPASS_MEM, 1'b0, 1'b1));
        step(alu(5'd5, 5'd4, 5'd3), want("ab_flush", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b1));
        step(alu(5'd5, 5'd4, 5'd3), want("ab_run", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b0));
        checkCounts("ab_counts", 32'd1, 32'd2);
    endtask

    task automatic test_saturation_and_reset();
        idleSteps();
        @(posedge clk);
        hz.stallCountLoad = 1'b1;
        hz.countLoadValue = 32'hFFFF_FFFE;
        @(posedge clk);
        hz.stallCountLoad = 1'b0;
        #1;
        checkCounts("sat_preload", 32'hFFFF_FFFE, 32'd2);
        for (int n = 0; n < 3; n++) begin
            step(ld(5'd3, 5'd1), want("sat_lw", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b0));
            step(alu(5'd4, 5'd3, 5'd3), want("sat_stall", BYPASS_EXEC, BYPASS_EXEC, 1'b1, 1'b0));
            step(alu(5'd4, 5'd3, 5'd3), want("sat_release", BYPASS_MEM, BYPASS_MEM, 1'b0, 1'b0));
            checkCounts("sat_hold", 32'hFFFF_FFFF, 32'd2);
        end
        step(ld(5'd3, 5'd1), want("rst_lw", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b0));
        step(alu(5'd4, 5'd3, 5'd3), want("rst_stall", BYPASS_EXEC, BYPASS_EXEC, 1'b1, 1'b0));
        @(posedge clk);
        #1;
        checks++;
        if (hz.op1BypassCtrl !== BYPASS_MEM) begin
            failures++;
            $display("FAIL rst_in_stall op1BypassCtrl: got %0d want %0d", hz.op1BypassCtrl, BYPASS_MEM);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({hz.stallFetch, hz.stallDecode, hz.flushDecode} !== 3'b000) begin
            failures++;
            $display("FAIL rst_mid controls: got %b want 000",
                     {hz.stallFetch, hz.stallDecode, hz.flushDecode});
        end
        checks++;
        if (hz.op1BypassCtrl !== BYPASS_NONE || hz.op2BypassCtrl !== BYPASS_NONE) begin
            failures++;
            $display("FAIL rst_mid bypass: got %0d/%0d want 0/0", hz.op1BypassCtrl, hz.op2BypassCtrl);
        end
        checkCounts("rst_mid", 32'd0, 32'd0);
        @(posedge clk);
        rst = 1'b1;
        step(alu(5'd4, 5'd3, 5'd3), want("rst_after", BYPASS_NONE, BYPASS_NONE, 1'b0, 1'b0));
        checkCounts("rst_after", 32'd0, 32'd0);
    endtask

    initial begin
        hz.stallCountLoad = 1'b0;
        hz.flushCountLoad = 1'b0;
        hz.countLoadValue = '0;
        drive(idle());
        test_reset();
        test_exec_bypass();
        test_mem_bypass();
        test_load_use();
        test_x0_and_unused();
        test_miss_and_load();
        test_stall_abort();
        test_saturation_and_reset();
        @(posedge clk);
        #3;
        checks++;
        if (scoreboard.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", scoreboard.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
